gas_pump_dispenser: RTL



---
 rtl/gas_pump_pkg.sv | 43 ++++
 rtl/seg7_decoder.sv | 11 +
 rtl/gas_pump_dispenser.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/gas_pump_pkg.sv
// Shared definitions for the gas pump dispenser: FSM state encoding and
// active-high 7-segment patterns (segment order gfedcba).
package gas_pump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CALC     = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_DONE     = 2'd3
    } pump_state_t;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Decimal digit to segment pattern; non-decimal codes show blank.
    function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit digit to 7-segment (gfedcba, active-high) decoder.
module seg7_decoder
    import gas_pump_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    assign segments = seg_lookup(digit);

endmodule

// File: rtl/gas_pump_dispenser.sv
// Metered, credit-limited fuel dispenser.
// IDLE latches the request, CALC finds the deliverable volume by repeated
// subtraction of the price from the credit, DISPENSE delivers one litre per
// FLOW_DIV cycles, DONE pulses for one cycle.
// Optional macro GAS_PUMP_SEG_EN builds the two-digit 7-segment readout of
// running_cost mod 100; without it both digit outputs are blank.
module gas_pump_dispenser
    import gas_pump_pkg::*;
#(
    parameter int FUEL_W   = 8,
    parameter int PRICE_W  = 8,
    parameter int CREDIT_W = 16,
    parameter int N_GRADES = 4,
    parameter int FLOW_DIV = 4,
    parameter int COST_W   = FUEL_W + PRICE_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic [$clog2(N_GRADES)-1:0] grade_sel,
    input  logic [N_GRADES*PRICE_W-1:0] price_table,
    input  logic [FUEL_W-1:0]           fuel_in_tank,
    input  logic [FUEL_W-1:0]           tank_capacity,
    input  logic [CREDIT_W-1:0]         customer_credit,
    output logic                        busy,
    output logic [FUEL_W-1:0]           fuel_dispensed,
    output logic [COST_W-1:0]           running_cost,
    output logic                        limited_by_credit,
    output logic [6:0]                  seg_digit1,
    output logic [6:0]                  seg_digit2,
    output logic                        done
);

    localparam logic [1:0] S_IDLE     = ST_IDLE;
    localparam logic [1:0] S_CALC     = ST_CALC;
    localparam logic [1:0] S_DISPENSE = ST_DISPENSE;
    localparam logic [1:0] S_DONE     = ST_DONE;

    localparam int FLOW_W = (FLOW_DIV > 1) ? $clog2(FLOW_DIV) : 1;
    localparam logic [FLOW_W-1:0] FLOW_LAST = FLOW_W'(FLOW_DIV - 1);

    logic [1:0]          state_reg;
    logic [PRICE_W-1:0]  price_reg;
    logic [FUEL_W-1:0]   target_reg;
    logic [FUEL_W-1:0]   amount_reg;
    logic [CREDIT_W-1:0] remainder_reg;
    logic [FUEL_W-1:0]   fuel_reg;
    logic [COST_W-1:0]   cost_reg;
    logic                limited_reg;
    logic [FLOW_W-1:0]   flow_reg;

    logic [PRICE_W-1:0]  price_arr [N_GRADES];
    logic [FUEL_W-1:0]   target_next;
    logic [FUEL_W-1:0]   fuel_next;
    logic [COST_W-1:0]   cost_next;
    logic                flow_wrap;
    logic                can_buy;

    // Unpack the flat price table so the grade index selects a whole word.
    generate
        for (genvar gi = 0; gi < N_GRADES; gi++) begin : g_price
            assign price_arr[gi] = price_table[gi*PRICE_W +: PRICE_W];
        end
    endgenerate

    assign target_next = (tank_capacity > fuel_in_tank) ? (tank_capacity - fuel_in_tank) : '0;
    assign fuel_next   = fuel_reg + 1'b1;
    assign cost_next   = cost_reg + COST_W'(price_reg);
    assign flow_wrap   = (flow_reg == FLOW_LAST);
    assign can_buy     = (remainder_reg >= CREDIT_W'(price_reg)) && (amount_reg < target_reg);

    // Transaction FSM with credit check and metered delivery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            price_reg     <= '0;
            target_reg    <= '0;
            amount_reg    <= '0;
            remainder_reg <= '0;
            fuel_reg      <= '0;
            cost_reg      <= '0;
            limited_reg   <= 1'b0;
            flow_reg      <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        price_reg     <= price_arr[grade_sel];
                        target_reg    <= target_next;
                        remainder_reg <= customer_credit;
                        amount_reg    <= '0;
                        fuel_reg      <= '0;
                        cost_reg      <= '0;
                        limited_reg   <= 1'b0;
                        flow_reg      <= '0;
                        state_reg     <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (price_reg == '0) begin
                        // Free fuel: credit is irrelevant, deliver the full target.
                        amount_reg  <= target_reg;
                        limited_reg <= 1'b0;
                        state_reg   <= (target_reg == '0) ? S_DONE : S_DISPENSE;
                    end else if (can_buy) begin
                        remainder_reg <= remainder_reg - CREDIT_W'(price_reg);
                        amount_reg    <= amount_reg + 1'b1;
                    end else begin
                        limited_reg <= (amount_reg < target_reg);
                        state_reg   <= (amount_reg == '0) ? S_DONE : S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    if (flow_wrap) begin
                        // A litre completing in the same cycle as stop still counts.
                        flow_reg <= '0;
                        fuel_reg <= fuel_next;
                        cost_reg <= cost_next;
                        if ((fuel_next == amount_reg) || stop) begin
                            state_reg <= S_DONE;
                        end
                    end else begin
                        flow_reg <= flow_reg + 1'b1;
                        if (stop) begin
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy              = (state_reg == S_CALC) || (state_reg == S_DISPENSE);
    assign done              = (state_reg == S_DONE);
    assign fuel_dispensed    = fuel_reg;
    assign running_cost      = cost_reg;
    assign limited_by_credit = limited_reg;

`ifdef GAS_PUMP_SEG_EN
    logic [COST_W-1:0] cost_mod;
    logic [3:0]        ones_digit;
    logic [3:0]        tens_digit;
    logic [6:0]        ones_seg;
    logic [6:0]        tens_seg;
    logic [6:0]        seg1_reg;
    logic [6:0]        seg2_reg;

    assign cost_mod   = cost_reg % COST_W'(100);
    assign ones_digit = 4'(cost_mod % COST_W'(10));
    assign tens_digit = 4'(cost_mod / COST_W'(10));

    seg7_decoder u_ones (
        .digit    (ones_digit),
        .segments (ones_seg)
    );

    seg7_decoder u_tens (
        .digit    (tens_digit),
        .segments (tens_seg)
    );

    // Register the decoded digits; the display lags running_cost by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg1_reg <= SEG_0;
            seg2_reg <= SEG_0;
        end else begin
            seg1_reg <= ones_seg;
            seg2_reg <= tens_seg;
        end
    end

    assign seg_digit1 = seg1_reg;
    assign seg_digit2 = seg2_reg;
`else
    assign seg_digit1 = SEG_BLANK;
    assign seg_digit2 = SEG_BLANK;
`endif

endmodule
